// File: rtl/uart_apb_fifo_regif.sv
// uart_apb_fifo_regif: APB register front-end for the UART.
// Holds the TX and RX character FIFOs and the DR/FR/IFLS/IMSC/RIS/MIS/ICR
// registers, and produces the TX, RX and combined interrupt lines.
// Optional feature: define UART_APB_LVL_REG_EN to add the read-only level
// register at byte offset 0x050 ({RX level, TX level}).
module uart_apb_fifo_regif #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:2]       PADDR,
  input  logic [15:0]       PWDATA,
  output logic [15:0]       PRDATA,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [2:0]        rx_err,
  input  logic              rx_valid,
  output logic              UARTTXINTR,
  output logic              UARTRXINTR,
  output logic              UARTINTR
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int RXW = DATA_W + 3;

  // Word addresses (byte offset >> 2)
  localparam logic [9:0] ADDR_DR   = 10'h000;
  localparam logic [9:0] ADDR_FR   = 10'h006;
  localparam logic [9:0] ADDR_IFLS = 10'h00D;
  localparam logic [9:0] ADDR_IMSC = 10'h00E;
  localparam logic [9:0] ADDR_RIS  = 10'h00F;
  localparam logic [9:0] ADDR_MIS  = 10'h010;
  localparam logic [9:0] ADDR_ICR  = 10'h011;
  localparam logic [9:0] ADDR_LVL  = 10'h014;

  localparam logic [10:0] IMSC_BITS = 11'h430;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [RXW-1:0]    rx_mem [FIFO_DEPTH];

  logic [LW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, oe_set, oe_clr;
  logic          wr_acc, rd_acc, rd_setup;
  logic [5:0]    ifls;
  logic [10:0]   imsc, ris, mis;
  logic          oeris, started;
  logic [RXW-1:0] rx_head;
  logic [15:0]   rd_val;
  logic          unused_ok;

  assign unused_ok = &{1'b0, PWDATA};

  // Maps an IFLS select code to a FIFO level threshold (5..7 act as 4).
  function automatic logic [LW-1:0] trig(input logic [2:0] sel);
    case (sel)
      3'd0:    return LW'(FIFO_DEPTH / 8);
      3'd1:    return LW'(FIFO_DEPTH / 4);
      3'd2:    return LW'(FIFO_DEPTH / 2);
      3'd3:    return LW'(FIFO_DEPTH * 3 / 4);
      default: return LW'(FIFO_DEPTH * 7 / 8);
    endcase
  endfunction

  assign wr_acc   = PSEL &  PENABLE &  PWRITE;
  assign rd_acc   = PSEL &  PENABLE & ~PWRITE;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

  assign tx_level = tx_wr - tx_rd;
  assign rx_level = rx_wr - rx_rd;
  assign tx_full  = (tx_level == DEPTH_L);
  assign rx_full  = (rx_level == DEPTH_L);
  assign tx_empty = (tx_level == '0);
  assign rx_empty = (rx_level == '0);

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign tx_pop  = tx_valid & tx_ready;
  assign tx_push = wr_acc & (PADDR == ADDR_DR) & (~tx_full | tx_pop);
  assign rx_pop  = rd_acc & (PADDR == ADDR_DR) & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign oe_set  = rx_valid & rx_full & ~rx_pop;
  assign oe_clr  = wr_acc & (PADDR == ADDR_ICR) & PWDATA[10];

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_valid ? tx_mem[tx_rd[AW-1:0]] : '0;
  assign rx_head  = rx_mem[rx_rd[AW-1:0]];

  assign ris = {oeris, 4'b0,
                started & (tx_level <= trig(ifls[2:0])),
                started & (rx_level >= trig(ifls[5:3])),
                4'b0};
  assign mis = ris & imsc;

  assign UARTRXINTR = mis[4];
  assign UARTTXINTR = mis[5];
  assign UARTINTR   = |mis;

  // FIFO storage writes.
  // NOTE: storage arrays are deliberately not reset; validity is tracked by the pointers alone.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= {rx_err, rx_data};
  end

  // Read-data multiplexer for the addressed register.
  // NOTE: default assignment first so every path assigns rd_val and no latch is inferred.
  always_comb begin
    rd_val = '0;
    case (PADDR)
      ADDR_DR:   rd_val = rx_empty ? '0
                                   : 16'({oeris, rx_head[RXW-1 -: 3], 8'(rx_head[DATA_W-1:0])});
      ADDR_FR:   rd_val = 16'({tx_empty, rx_full, tx_full, rx_empty, tx_valid, 3'b0});
      ADDR_IFLS: rd_val = 16'(ifls);
      ADDR_IMSC: rd_val = 16'(imsc);
      ADDR_RIS:  rd_val = 16'(ris);
      ADDR_MIS:  rd_val = 16'(mis);
`ifdef UART_APB_LVL_REG_EN
      ADDR_LVL:  rd_val = {8'(rx_level), 8'(tx_level)};
`else
      ADDR_LVL:  rd_val = '0;
`endif
      default:   rd_val = '0;
    endcase
  end

  // Pointers, control registers, sticky overrun flag and read-data capture.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_wr   <= '0;
      tx_rd   <= '0;
      rx_wr   <= '0;
      rx_rd   <= '0;
      ifls    <= 6'b010_010;
      imsc    <= '0;
      oeris   <= 1'b0;
      started <= 1'b0;
      PRDATA  <= '0;
    end else begin
      started <= 1'b1;
      if (tx_push) tx_wr <= tx_wr + LW'(1);
      if (tx_pop)  tx_rd <= tx_rd + LW'(1);
      if (rx_push) rx_wr <= rx_wr + LW'(1);
      if (rx_pop)  rx_rd <= rx_rd + LW'(1);
      if (wr_acc && PADDR == ADDR_IFLS) ifls <= PWDATA[5:0];
      if (wr_acc && PADDR == ADDR_IMSC) imsc <= PWDATA[10:0] & IMSC_BITS;
      // A new overrun in the same cycle as an ICR clear keeps the flag set.
      if (oe_set)      oeris <= 1'b1;
      else if (oe_clr) oeris <= 1'b0;
      if (rd_setup) PRDATA <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart_apb_fifo_regif.sv
// Self-checking bench for uart_apb_fifo_regif (DATA_W=8, FIFO_DEPTH=16).
// A queue-based model predicts every output on every cycle; directed
// sequences add literal expectations, then a randomized phase follows.
module tb_uart_apb_fifo_regif;

  localparam int D = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:2] PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [2:0]  rx_err = '0;
  logic        rx_valid = 1'b0;
  logic        UARTTXINTR, UARTRXINTR, UARTINTR;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit rand_en = 0;

  uart_apb_fifo_regif #(.DATA_W(8), .FIFO_DEPTH(D)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid),
    .UARTTXINTR(UARTTXINTR), .UARTRXINTR(UARTRXINTR), .UARTINTR(UARTINTR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_tx_q[$];
  logic [10:0] m_rx_q[$];      // {err[2:0], data[7:0]}
  bit          m_oeris = 0;
  bit          m_started = 0;
  logic [5:0]  m_ifls = 6'h12;
  logic [10:0] m_imsc = '0;
  logic [15:0] m_prdata = '0;

  function automatic int trig(input int sel);
    int eighths[5] = '{1, 2, 4, 6, 7};
    return (sel > 4) ? D * 7 / 8 : D * eighths[sel] / 8;
  endfunction

  function automatic logic [10:0] m_ris();
    logic [10:0] r = '0;
    r[10] = m_oeris;
    r[5]  = m_started && (m_tx_q.size() <= trig(int'(m_ifls[2:0])));
    r[4]  = m_started && (m_rx_q.size() >= trig(int'(m_ifls[5:3])));
    return r;
  endfunction

  function automatic logic [15:0] m_read(input logic [9:0] a);
    logic [15:0] v = '0;
    case (a)
      10'h000: if (m_rx_q.size() > 0) v = {4'b0, m_oeris, m_rx_q[0]};
      10'h006: v = {8'b0, m_tx_q.size() == 0, m_rx_q.size() == D, m_tx_q.size() == D,
                    m_rx_q.size() == 0, m_tx_q.size() > 0, 3'b0};
      10'h00D: v = {10'b0, m_ifls};
      10'h00E: v = {5'b0, m_imsc};
      10'h00F: v = {5'b0, m_ris()};
      10'h010: v = {5'b0, m_ris() & m_imsc};
`ifdef UART_APB_LVL_REG_EN
      10'h014: v = {8'(m_rx_q.size()), 8'(m_tx_q.size())};
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_oeris = 0; m_started = 0; m_ifls = 6'h12; m_imsc = '0; m_prdata = '0;
    end else begin : step
      int  tx_n, rx_n;
      bit  txpop, rxpop, wr, rd;
      tx_n  = m_tx_q.size();
      rx_n  = m_rx_q.size();
      wr    = PSEL && PENABLE && PWRITE;
      rd    = PSEL && PENABLE && !PWRITE;
      if (PSEL && !PENABLE && !PWRITE) m_prdata = m_read(PADDR);
      txpop = tx_ready && tx_n > 0;
      rxpop = rd && PADDR == 10'h000 && rx_n > 0;
      if (txpop) void'(m_tx_q.pop_front());
      if (rxpop) void'(m_rx_q.pop_front());
      if (wr && PADDR == 10'h000 && (tx_n < D || txpop)) m_tx_q.push_back(PWDATA[7:0]);
      if (wr && PADDR == 10'h011 && PWDATA[10]) m_oeris = 0;
      if (rx_valid) begin
        if (rx_n < D || rxpop) m_rx_q.push_back({rx_err, rx_data});
        else m_oeris = 1;
      end
      if (wr && PADDR == 10'h00D) m_ifls = PWDATA[5:0];
      if (wr && PADDR == 10'h00E) m_imsc = PWDATA[10:0] & 11'h430;
      m_started = 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge PCLK) begin
    if (cmp_en) begin : cmp
      logic [10:0] mis;
      mis = m_ris() & m_imsc;
      check("tx_valid", {31'b0, tx_valid}, {31'b0, m_tx_q.size() > 0});
      check("tx_data", {24'b0, tx_data}, (m_tx_q.size() > 0) ? {24'b0, m_tx_q[0]} : 32'd0);
      check("PRDATA", {16'b0, PRDATA}, {16'b0, m_prdata});
      check("UARTRXINTR", {31'b0, UARTRXINTR}, {31'b0, mis[4]});
      check("UARTTXINTR", {31'b0, UARTTXINTR}, {31'b0, mis[5]});
      check("UARTINTR", {31'b0, UARTINTR}, {31'b0, |mis});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apb_write(input logic [9:0] a, input logic [15:0] d);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [15:0] d);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic rx_push(input logic [7:0] d, input logic [2:0] e);
    @(posedge PCLK); #1;
    rx_valid = 1; rx_data = d; rx_err = e;
    @(posedge PCLK); #1;
    rx_valid = 0;
  endtask

  // Raises tx_ready and records the head on every cycle until the FIFO empties.
  task automatic tx_drain(output logic [7:0] seq[$]);
    seq.delete();
    @(posedge PCLK); #1;
    tx_ready = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge PCLK);
      if (!tx_valid) break;
      seq.push_back(tx_data);
    end
    @(posedge PCLK); #1;
    tx_ready = 0;
  endtask

  // Background random driver for the stream inputs.
  initial forever begin
    @(posedge PCLK); #1;
    if (rand_en) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      rx_err   = 3'($urandom);
      tx_ready = 1'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [15:0] rd;
  logic [7:0]  seq[$];
  logic [9:0]  addr_tbl[9] = '{10'h000, 10'h006, 10'h00D, 10'h00E, 10'h00F,
                               10'h010, 10'h011, 10'h014, 10'h3FF};

  initial begin
    #1 PRESETn = 0;
    cmp_en = 1;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1;

    // Some activity, then reset in the middle of an APB write.
    apb_write(10'h00E, 16'h0430);
    apb_write(10'h000, 16'h0011);
    rx_push(8'h42, 3'b000);
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 1; PADDR = 10'h000; PWDATA = 16'h0099;
    #3 PRESETn = 0;
    #2 PSEL = 0; PWRITE = 0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1;

    check("reset tx_valid", {31'b0, tx_valid}, 0);
    check("reset tx_data", {24'b0, tx_data}, 0);
    check("reset UARTINTR", {31'b0, UARTINTR}, 0);
    apb_read(10'h006, rd); check("reset FR", {16'b0, rd}, 32'h0090);
    apb_read(10'h00D, rd); check("reset IFLS", {16'b0, rd}, 32'h0012);
    apb_read(10'h010, rd); check("reset MIS", {16'b0, rd}, 32'h0000);

    // TX fill and drain.
    for (int i = 0; i <= 16; i++) apb_write(10'h000, 16'(i));
    apb_read(10'h006, rd); check("tx full FR", {16'b0, rd}, 32'h0038);
    tx_drain(seq);
    check("tx drain count", seq.size(), 16);
    for (int i = 0; i < seq.size(); i++) check("tx drain order", {24'b0, seq[i]}, i);

    // RX overrun.
    apb_write(10'h00E, 16'h0400);
    for (int i = 0; i < 17; i++) rx_push(8'(i), 3'b000);
    @(negedge PCLK); check("overrun UARTINTR", {31'b0, UARTINTR}, 1);
    apb_read(10'h00F, rd); check("overrun RIS", {16'b0, rd}, 32'h0430);
    apb_read(10'h000, rd); check("overrun DR", {16'b0, rd}, 32'h0800);
    apb_write(10'h011, 16'h0400);
    @(negedge PCLK); check("ICR clears UARTINTR", {31'b0, UARTINTR}, 0);
    for (int i = 0; i < 15; i++) apb_read(10'h000, rd);
    check("overrun last DR", {16'b0, rd}, 32'h000F);

    // RX trigger at level 8.
    apb_write(10'h00D, 16'h0012);
    apb_write(10'h00E, 16'h0010);
    for (int i = 0; i < 7; i++) rx_push(8'h30 + 8'(i), 3'b000);
    @(negedge PCLK); check("rx trig below", {31'b0, UARTRXINTR}, 0);
    rx_push(8'h37, 3'b000);
    @(negedge PCLK); check("rx trig reached", {31'b0, UARTRXINTR}, 1);
    apb_read(10'h000, rd); check("rx trig DR", {16'b0, rd}, 32'h0030);
    @(negedge PCLK); check("rx trig falls", {31'b0, UARTRXINTR}, 0);
    for (int i = 0; i < 7; i++) apb_read(10'h000, rd);
    apb_write(10'h00E, 16'h0000);

    // Error flags and empty read.
    rx_push(8'hA5, 3'b011);
    apb_read(10'h000, rd); check("err DR", {16'b0, rd}, 32'h03A5);
    apb_read(10'h000, rd); check("empty DR", {16'b0, rd}, 32'h0000);
    apb_read(10'h006, rd); check("empty FR", {16'b0, rd}, 32'h0090);

    // Full TX: write coinciding with a pop.
    for (int i = 0; i < 16; i++) apb_write(10'h000, 16'h20 + 16'(i));
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 10'h000; PWDATA = 16'h0055;
    @(posedge PCLK); #1;
    PENABLE = 1; tx_ready = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; tx_ready = 0;
    apb_read(10'h006, rd); check("simul tx FR", {16'b0, rd}, 32'h0038);
    apb_read(10'h014, rd);
`ifdef UART_APB_LVL_REG_EN
    check("LVL reg", {16'b0, rd}, 32'h0010);
`else
    check("LVL unmapped", {16'b0, rd}, 32'h0000);
`endif
    tx_drain(seq);
    check("simul tx count", seq.size(), 16);
    if (seq.size() == 16) begin
      check("simul tx first", {24'b0, seq[0]}, 32'h21);
      check("simul tx last", {24'b0, seq[15]}, 32'h55);
    end

    // Full RX: push coinciding with a DR pop gives no overrun.
    for (int i = 0; i < 16; i++) rx_push(8'h60 + 8'(i), 3'b000);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 10'h000;
    @(posedge PCLK); #1;
    PENABLE = 1; rx_valid = 1; rx_data = 8'h77; rx_err = 3'b100;
    @(negedge PCLK); check("simul rx DR", {16'b0, PRDATA}, 32'h0060);
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; rx_valid = 0;
    apb_read(10'h00F, rd); check("simul rx RIS", {16'b0, rd}, 32'h0030);
    for (int i = 0; i < 16; i++) apb_read(10'h000, rd);
    check("simul rx last", {16'b0, rd}, 32'h0477);

    // Randomized traffic.
    rand_en = 1;
    for (int n = 0; n < 600; n++) begin
      logic [9:0] a;
      a = addr_tbl[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 0) apb_write(a, 16'($urandom));
      else apb_read(a, rd);
    end
    @(posedge PCLK); #1;
    rand_en = 0;
    rx_valid = 0; tx_ready = 0;
    repeat (3) @(posedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_fifo_regif.md
# uart_apb_fifo_regif

Parametrised APB register front-end for the UART, and the successor to the current fixed-width APB port shell. It decodes APB accesses on `PCLK` and implements the data, flag, FIFO-level-select and interrupt registers. It buffers transmit and receive characters in FIFOs of configurable depth and width. It drives a valid/ready stream into the transmitter core, accepts a valid-only stream from the receiver core, and generates the TX, RX and combined interrupt lines.

## Interface
- `DATA_W`, 8: character width in bits; legal range 5..8.
- `FIFO_DEPTH`, 16: entries per FIFO; must be a power of two, ≥ 8.
- `PCLK` in 1: sole clock; all state on rising edge.
- `PRESETn` in 1: asynchronous active-low reset.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PADDR` in [11:2]: word address.
- `PWDATA` in 16: write data.
- `PRDATA` out 16: read data, registered.
- `tx_data` out `DATA_W`: TX FIFO head.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: transmitter accepts head.
- `rx_data` in `DATA_W`: received character.
- `rx_err` in 3: {BE, PE, FE} for `rx_data`.
- `rx_valid` in 1: one-cycle push strobe.
- `UARTTXINTR` out 1: masked TX level interrupt.
- `UARTRXINTR` out 1: masked RX level interrupt.
- `UARTINTR` out 1: OR of all masked interrupts.

## Operation
- **APB protocol**
  - No wait states.
  - A write commits on the access cycle (`PSEL & PENABLE & PWRITE`).
  - A read captures `PRDATA` on the setup cycle (`PSEL & !PENABLE & !PWRITE`), so `PRDATA` holds valid data during the access cycle.
  - Unmapped reads return 0. Writes to read-only or unmapped offsets are ignored.
- **Register map** (byte offsets):
  - 0x000 DR.
    - Write: pushes `PWDATA[DATA_W-1:0]` into the TX FIFO.
    - Read: returns `{4'b0, OE, BE, PE, FE, data}`, with data in bits [7:0] zero-extended and FE/PE/BE/OE in bits 8..11. It pops the RX FIFO on the access cycle.
    - Read with RX FIFO empty: returns 0 and does not pop.
  - 0x018 FR (RO): bit3 BUSY (= `tx_valid`), bit4 RXFE, bit5 TXFF, bit6 RXFF, bit7 TXFE.
  - 0x034 IFLS: bits [2:0] TX select, bits [5:3] RX select.
    - Encoding: 0..4 = 1/8, 1/4, 1/2, 3/4, 7/8 of `FIFO_DEPTH`; 5..7 are treated as 4.
  - 0x038 IMSC: bit4 RXIM, bit5 TXIM, bit10 OEIM.
  - 0x03C RIS (RO).
  - 0x040 MIS (RO) = RIS & IMSC.
  - 0x044 ICR (WO): writing 1 to bit10 clears OERIS.
- **TX FIFO**
  - A push when full is dropped and the FIFO is unchanged. TX overflow is not flagged.
  - `tx_valid` = not empty; `tx_data` = head entry.
  - The head pops on `tx_valid & tx_ready`.
- **RX FIFO**
  - Each entry is `DATA_W`+3 bits: data plus error flags.
  - `rx_valid` pushes one entry.
  - Push when full (and no simultaneous pop): the character is discarded, OERIS is set, and the OE bit of the DR read path is set. OE stays set until cleared through ICR.
- **Interrupt sources**
  - RXRIS (bit4) = RX level ≥ RX trigger; level-sensitive.
  - TXRIS (bit5) = TX level ≤ TX trigger; level-sensitive.
  - OERIS (bit10) is sticky.
- **Interrupt outputs**
  - `UARTRXINTR` = MIS[4].
  - `UARTTXINTR` = MIS[5].
  - `UARTINTR` = |MIS.
- **Simultaneous push and pop** on the same FIFO in the same cycle:
  - Full FIFO: the push is accepted and the level is unchanged. No overrun on RX.
  - Empty FIFO: the pop is ignored and the push proceeds.
- **Simultaneous OE set and ICR clear** in the same cycle: set wins.
- Levels and pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·`FIFO_DEPTH`.

## Timing
- **Reset** (asynchronous on `PRESETn` low, released synchronously by design):
  - FIFOs empty, `PRDATA`=0, IMSC=0, OERIS=0, IFLS=6'b010_010.
  - Outputs at reset: `tx_valid`=0, `tx_data`=0, all interrupt outputs 0.
  - TXRIS becomes 1 on the first cycle after reset release (empty TX FIFO is ≤ trigger). It is masked, so no output asserts.
- **Reset mid-transfer:** an in-flight APB access is abandoned and FIFO contents are lost.
- **TX latency:** the DR write access edge → `tx_valid`=1 on the next cycle.
- **RX latency:** the `rx_valid` edge → RXFE=0 and the updated level on the next cycle.
- **Interrupt outputs:** combinational from registered state. They update one cycle after the causing edge.
- **Back-to-back reads:** two DR reads in consecutive APB transfers return consecutive FIFO entries.

## Configuration
- `UART_APB_LVL_REG_EN` defined: adds read-only register 0x050 returning {RX level in [15:8], TX level in [7:0]}, each zero-extended.
- `UART_APB_LVL_REG_EN` undefined: offset 0x050 is unmapped and reads 0.

## Test plan
- **Reset values:** assert `PRESETn`=0 mid-operation, then release.
  - FR reads 0x0090, IFLS reads 0x0012, MIS reads 0.
  - All outputs are 0, except `UARTINTR`, which stays 0 because it is masked.
- **TX fill and drain** (`FIFO_DEPTH`=16, `tx_ready`=0):
  - Write DR 17 times with 0x00..0x10: FR.TXFF=1 and the 0x10 write is dropped.
  - Raise `tx_ready`: `tx_data` sequence is 0x00..0x0F, then `tx_valid`=0.
- **RX overrun:** push 17 characters with IMSC=0x400.
  - OERIS=1 and `UARTINTR`=1.
  - DR read returns 0x800|0x00.
  - Writing ICR=0x400 clears `UARTINTR`.
- **RX trigger:** IFLS RX select 2, RXIM=1.
  - `UARTRXINTR` rises the cycle after the 8th push.
  - It falls after the first DR read pops the level to 7.
- **Error flags and empty read:** push 0xA5 with `rx_err`=3'b011. DR reads 0x03A5, and a second read returns 0 with the level unchanged.
- **Simultaneous operations:** full TX FIFO with a DR write coinciding with a `tx_ready` pop → level stays 16 and the new data arrives last. With `UART_APB_LVL_REG_EN` defined, 0x050 reads 0x0010.
